// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, immediate formats, control bundle and ALU encodings.
// The execute stage decodes alu_op with the same constants.
package riscv_pkg;
  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       alu_src_imm;
    logic       alu_src_pc;
    logic [3:0] alu_op;
    logic [1:0] result_src;
  } ctrl_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    ctrl_t           ctrl;
  } idex_t;

  // alt selects SUB/SRA; callers gate it for OP-IMM so addi never becomes a subtract
  function automatic logic [3:0] alu_op_f(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/decode_stage_if.sv
// Decode-stage bus: IF/ID inputs, regfile and writeback hookup, ID/EX outputs.
interface decode_stage_if;
  import riscv_pkg::*;
  logic            id_valid_i;
  logic [XLEN-1:0] id_instr_i;
  logic [XLEN-1:0] id_pc_i;
  logic [4:0]      rs1_addr_o;
  logic [4:0]      rs2_addr_o;
  logic [XLEN-1:0] rd1_i;
  logic [XLEN-1:0] rd2_i;
  logic            wb_we_i;
  logic [4:0]      wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic            ex_flush_i;
  logic            stall_o;
  logic            ex_valid_o;
  logic [XLEN-1:0] ex_pc_o;
  logic [XLEN-1:0] ex_rs1_data_o;
  logic [XLEN-1:0] ex_rs2_data_o;
  logic [XLEN-1:0] ex_imm_o;
  logic [4:0]      ex_rs1_o;
  logic [4:0]      ex_rs2_o;
  logic [4:0]      ex_rd_o;
  ctrl_t           ex_ctrl_o;

  modport slave (
    input  id_valid_i, id_instr_i, id_pc_i, rd1_i, rd2_i, wb_we_i, wb_rd_i, wb_data_i, ex_flush_i,
    output rs1_addr_o, rs2_addr_o, stall_o, ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o,
           ex_imm_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_ctrl_o
  );
  modport master (
    output id_valid_i, id_instr_i, id_pc_i, rd1_i, rd2_i, wb_we_i, wb_rd_i, wb_data_i, ex_flush_i,
    input  rs1_addr_o, rs2_addr_o, stall_o, ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o,
           ex_imm_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_ctrl_o
  );
endinterface

// File: rtl/imm_gen.sv
// Sign-extended immediate for the five RV32I encodings.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:7]     instr_i,
  input  imm_sel_t        sel_i,
  output logic [XLEN-1:0] imm_o
);
  always_comb begin
    imm_o = '0;
    case (sel_i)
      IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U: imm_o = {instr_i[31:12], 12'b0};
      IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end
endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: control decode, WB bypass, load-use detection and the ID/EX register.
module decode_stage
  import riscv_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  decode_stage_if.slave bus
);
  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1, rs2, rd;
  ctrl_t           ctrl;
  imm_sel_t        imm_sel;
  logic            uses_rs1, uses_rs2;
  logic [XLEN-1:0] imm, rs1_data, rs2_data;
  logic            hazard, stall;
  idex_t           idex_d, idex_q;

  assign instr  = bus.id_instr_i;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  always_comb begin
    ctrl     = '0;
    imm_sel  = IMM_I;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_LUI: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.alu_op = ALU_PASSB;
        imm_sel = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.alu_src_pc = 1'b1;
        imm_sel = IMM_U;
      end
      OPC_JAL: begin
        ctrl.reg_write = 1'b1; ctrl.jump = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.alu_src_pc = 1'b1;
        ctrl.result_src = RES_PC4; imm_sel = IMM_J;
      end
      OPC_JALR: begin
        ctrl.reg_write = 1'b1; ctrl.jump = 1'b1; ctrl.jalr = 1'b1; ctrl.alu_src_imm = 1'b1;
        ctrl.result_src = RES_PC4; uses_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = (funct3[2:1] == 2'b10) ? ALU_SLT : (funct3[2:1] == 2'b11) ? ALU_SLTU : ALU_SUB;
        imm_sel = IMM_B; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.reg_write = 1'b1; ctrl.mem_read = 1'b1; ctrl.alu_src_imm = 1'b1;
        ctrl.result_src = RES_MEM; uses_rs1 = 1'b1;
      end
      OPC_STORE: begin
        ctrl.mem_write = 1'b1; ctrl.alu_src_imm = 1'b1;
        imm_sel = IMM_S; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1;
        ctrl.alu_op = alu_op_f(funct3, (funct3 == 3'b101) && instr[30]);
        uses_rs1 = 1'b1;
      end
      OPC_OP: begin
        ctrl.reg_write = 1'b1; ctrl.alu_op = alu_op_f(funct3, instr[30]);
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  imm_gen u_imm_gen (.instr_i(instr[31:7]), .sel_i(imm_sel), .imm_o(imm));

  // The regfile write lands on this same edge, so its read port is still stale
  assign rs1_data = (bus.wb_we_i && bus.wb_rd_i != 5'd0 && bus.wb_rd_i == rs1) ? bus.wb_data_i : bus.rd1_i;
  assign rs2_data = (bus.wb_we_i && bus.wb_rd_i != 5'd0 && bus.wb_rd_i == rs2) ? bus.wb_data_i : bus.rd2_i;

  assign hazard = idex_q.valid && idex_q.ctrl.mem_read && idex_q.rd != 5'd0 && bus.id_valid_i &&
                  ((uses_rs1 && idex_q.rd == rs1) || (uses_rs2 && idex_q.rd == rs2));
  assign stall  = hazard && !bus.ex_flush_i;

  // Flush and stall both leave an all-zero bubble in ID/EX
  always_comb begin
    idex_d = '0;
    if (!bus.ex_flush_i && !stall) begin
      idex_d.valid    = bus.id_valid_i;
      idex_d.pc       = bus.id_pc_i;
      idex_d.rs1_data = rs1_data;
      idex_d.rs2_data = rs2_data;
      idex_d.imm      = imm;
      idex_d.rs1      = rs1;
      idex_d.rs2      = rs2;
      idex_d.rd       = rd;
      idex_d.ctrl     = bus.id_valid_i ? ctrl : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign bus.rs1_addr_o    = rs1;
  assign bus.rs2_addr_o    = rs2;
  assign bus.stall_o       = stall;
  assign bus.ex_valid_o    = idex_q.valid;
  assign bus.ex_pc_o       = idex_q.pc;
  assign bus.ex_rs1_data_o = idex_q.rs1_data;
  assign bus.ex_rs2_data_o = idex_q.rs2_data;
  assign bus.ex_imm_o      = idex_q.imm;
  assign bus.ex_rs1_o      = idex_q.rs1;
  assign bus.ex_rs2_o      = idex_q.rs2;
  assign bus.ex_rd_o       = idex_q.rd;
  assign bus.ex_ctrl_o     = idex_q.ctrl;
endmodule
